audio_serial_rx: RTL and testbench

AUDIO_SERIAL_RX -- requirements
Module: audio_serial_rx

---
 rtl/audio_serial_rx_pkg.sv | 15 +
 rtl/audio_serial_rx_if.sv | 21 ++
 rtl/audio_serial_rx_sync_edge.sv | 42 ++++
 rtl/audio_serial_rx.sv | 147 ++++++++++++++
 tb/tb_audio_serial_rx.sv | 297 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/audio_serial_rx_pkg.sv
// audio_rx_pkg -- shared defaults and types for the audio serial receiver.
//   DEFAULT_WIDTH       : bits per channel word
//   DEFAULT_SYNC_STAGES : synchronizer depth for sck / lrck / sdin
//   ch_e                : channel selected by lrck (0 = left, 1 = right)
package audio_rx_pkg;

    localparam int DEFAULT_WIDTH       = 16;
    localparam int DEFAULT_SYNC_STAGES = 2;

    typedef enum logic {
        CH_LEFT  = 1'b0,
        CH_RIGHT = 1'b1
    } ch_e;

endpackage

// File: rtl/audio_serial_rx_if.sv
// audio_serial_rx_if -- stereo pair valid/ready handshake.
//   pair_valid : a stereo pair is held on left_out / right_out
//   pair_ready : consumer accepts when pair_valid && pair_ready
//   left_out   : left sample, two's complement
//   right_out  : right sample, two's complement
// master = receiver side, slave = consumer side.
interface audio_serial_rx_if
    import audio_rx_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) ();

    logic             pair_valid;
    logic             pair_ready;
    logic [WIDTH-1:0] left_out;
    logic [WIDTH-1:0] right_out;

    modport master (output pair_valid, output left_out, output right_out, input pair_ready);
    modport slave  (input pair_valid, input left_out, input right_out, output pair_ready);

endinterface

// File: rtl/audio_serial_rx_sync_edge.sv
// sync_edge -- multi-flop synchronizer with rise/fall detection.
//   clk, rst : system clock, synchronous active-high reset
//   d        : asynchronous input
//   level    : synchronized level
//   rise     : one-cycle pulse on a synchronized 0->1
//   fall     : one-cycle pulse on a synchronized 1->0
module sync_edge
    import audio_rx_pkg::*;
#(
    parameter int STAGES = DEFAULT_SYNC_STAGES
) (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic level,
    output logic rise,
    output logic fall
);

    logic [STAGES-1:0] chain;
    logic              prev;
    // Edges are masked until the chain and prev have refilled after reset,
    // so an input already high at reset is not mistaken for a transition.
    logic [STAGES:0]   primed;

    always_ff @(posedge clk) begin
        if (rst) begin
            chain  <= '0;
            prev   <= 1'b0;
            primed <= '0;
        end else begin
            chain  <= {chain[STAGES-2:0], d};
            prev   <= chain[STAGES-1];
            primed <= {primed[STAGES-1:0], 1'b1};
        end
    end

    assign level = chain[STAGES-1];
    assign rise  = primed[STAGES] &  level & ~prev;
    assign fall  = primed[STAGES] & ~level &  prev;

endmodule

// File: rtl/audio_serial_rx.sv
// audio_serial_rx -- left-justified serial audio receiver with stereo
// pair valid/ready output.
//   clk, rst   : system clock (>= 4x sck), synchronous active-high reset
//   sck        : serial bit clock (asynchronous)
//   lrck       : word select, 0 = left, 1 = right
//   sdin       : serial data, MSB first
//   pair_if    : master side of the pair handshake (pair_valid/pair_ready,
//                left_out/right_out)
//   overrun    : one-cycle pulse when a completed pair is dropped
//   frame_err  : one-cycle pulse when a short word is discarded
// Optional (macro AUDIO_RX_PEAK_EN):
//   peak_clr   : clears the peak registers (wins over an update)
//   peak_l/r   : max |sample| of accepted pairs, WIDTH-1 bits, saturating
module audio_serial_rx
    import audio_rx_pkg::*;
#(
    parameter int WIDTH       = DEFAULT_WIDTH,
    parameter int SYNC_STAGES = DEFAULT_SYNC_STAGES
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 sck,
    input  logic                 lrck,
    input  logic                 sdin,
    audio_serial_rx_if.master    pair_if,
    output logic                 overrun,
    output logic                 frame_err
`ifdef AUDIO_RX_PEAK_EN
    ,
    input  logic                 peak_clr,
    output logic [WIDTH-2:0]     peak_l,
    output logic [WIDTH-2:0]     peak_r
`endif
);

    localparam int STAGES = (SYNC_STAGES < 2) ? 2 : SYNC_STAGES;
    localparam int CW     = $clog2(WIDTH + 1);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);
    localparam logic [CW-1:0] FULL = CW'(WIDTH);

    logic sck_lvl, sck_rise, sck_fall;
    logic lrck_lvl, lrck_rise, lrck_fall;
    logic sdin_lvl, sdin_rise, sdin_fall;
    logic unused_edges;

    sync_edge #(.STAGES(STAGES)) u_sck  (.clk(clk), .rst(rst), .d(sck),
                                         .level(sck_lvl), .rise(sck_rise), .fall(sck_fall));
    sync_edge #(.STAGES(STAGES)) u_lrck (.clk(clk), .rst(rst), .d(lrck),
                                         .level(lrck_lvl), .rise(lrck_rise), .fall(lrck_fall));
    sync_edge #(.STAGES(STAGES)) u_sdin (.clk(clk), .rst(rst), .d(sdin),
                                         .level(sdin_lvl), .rise(sdin_rise), .fall(sdin_fall));

    assign unused_edges = &{1'b0, sck_lvl, sck_fall, sdin_rise, sdin_fall};

    logic             active;      // set by the first lrck transition after reset
    ch_e              chan;
    logic [CW-1:0]    bit_cnt;     // saturates at WIDTH; later bits are ignored
    logic [WIDTH-2:0] shreg;
    logic [WIDTH-1:0] left_stage;
    logic             staged;

    logic             lrck_edge, capture, word_done, new_pair, can_load;
    logic [WIDTH-1:0] word;

    always_comb begin
        lrck_edge = lrck_rise | lrck_fall;
        capture   = active & sck_rise & ~lrck_edge & (bit_cnt < FULL);
        word      = {shreg, sdin_lvl};
        word_done = capture && (bit_cnt == LAST);
        new_pair  = word_done && (chan == CH_RIGHT) && staged;
        can_load  = !pair_if.pair_valid || pair_if.pair_ready;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            active             <= 1'b0;
            chan               <= CH_LEFT;
            bit_cnt            <= '0;
            shreg              <= '0;
            left_stage         <= '0;
            staged             <= 1'b0;
            pair_if.pair_valid <= 1'b0;
            pair_if.left_out   <= '0;
            pair_if.right_out  <= '0;
            overrun            <= 1'b0;
            frame_err          <= 1'b0;
        end else begin
            frame_err <= 1'b0;
            overrun   <= 1'b0;

            if (lrck_edge) begin
                active  <= 1'b1;
                bit_cnt <= '0;
                chan    <= ch_e'(lrck_lvl);
                if (active && (bit_cnt != '0) && (bit_cnt < FULL)) begin
                    frame_err <= 1'b1;
                    if (chan == CH_RIGHT) staged <= 1'b0;
                end
            end else if (capture) begin
                shreg   <= word[WIDTH-2:0];
                bit_cnt <= bit_cnt + 1'b1;
                if (word_done) begin
                    if (chan == CH_LEFT) begin
                        left_stage <= word;
                        staged     <= 1'b1;
                    end else begin
                        staged     <= 1'b0;
                    end
                end
            end

            if (new_pair) begin
                if (can_load) begin
                    pair_if.pair_valid <= 1'b1;
                    pair_if.left_out   <= left_stage;
                    pair_if.right_out  <= word;
                end else begin
                    overrun <= 1'b1;
                end
            end else if (pair_if.pair_valid && pair_if.pair_ready) begin
                pair_if.pair_valid <= 1'b0;
            end
        end
    end

`ifdef AUDIO_RX_PEAK_EN
    // |s| with the most negative value saturating to the largest positive.
    function automatic logic [WIDTH-2:0] mag(input logic [WIDTH-1:0] s);
        logic [WIDTH-1:0] neg;
        neg = -s;
        if (!s[WIDTH-1])     return s[WIDTH-2:0];
        else if (neg[WIDTH-1]) return '1;
        else                 return neg[WIDTH-2:0];
    endfunction

    always_ff @(posedge clk) begin
        if (rst || peak_clr) begin
            peak_l <= '0;
            peak_r <= '0;
        end else if (pair_if.pair_valid && pair_if.pair_ready) begin
            if (mag(pair_if.left_out)  > peak_l) peak_l <= mag(pair_if.left_out);
            if (mag(pair_if.right_out) > peak_r) peak_r <= mag(pair_if.right_out);
        end
    end
`endif

endmodule

// File: tb/tb_audio_serial_rx.sv
module tb_audio_serial_rx;

    localparam int W = 16;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic sck = 1'b0;
    logic lrck = 1'b1;
    logic sdin = 1'b0;
    logic overrun, frame_err;
`ifdef AUDIO_RX_PEAK_EN
    logic peak_clr = 1'b0;
    logic [W-2:0] peak_l, peak_r;
`endif

    audio_serial_rx_if #(.WIDTH(W)) bus ();

    audio_serial_rx #(.WIDTH(W), .SYNC_STAGES(2)) dut (
        .clk       (clk),
        .rst       (rst),
        .sck       (sck),
        .lrck      (lrck),
        .sdin      (sdin),
        .pair_if   (bus),
        .overrun   (overrun),
        .frame_err (frame_err)
`ifdef AUDIO_RX_PEAK_EN
        ,
        .peak_clr  (peak_clr),
        .peak_l    (peak_l),
        .peak_r    (peak_r)
`endif
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    // ---------------- monitor ----------------
    logic [31:0] load_q[$];
    int ovr_cnt = 0, ferr_cnt = 0, change_cnt = 0, coin_cnt = 0, valid_cyc = 0;
    logic [31:0] coin_val = '0;
    logic prev_valid = 1'b0, prev_acc = 1'b0;
    logic [31:0] prev_val = '0;

    always @(negedge clk) begin
        if (rst) begin
            prev_valid = 1'b0;
            prev_acc   = 1'b0;
        end else begin
            if (bus.pair_valid && (!prev_valid || prev_acc)) begin
                load_q.push_back({bus.left_out, bus.right_out});
                if (prev_valid && prev_acc) begin
                    coin_cnt++;
                    coin_val = {bus.left_out, bus.right_out};
                end
            end
            if (prev_valid && !prev_acc &&
                (!bus.pair_valid || ({bus.left_out, bus.right_out} != prev_val)))
                change_cnt++;
            if (bus.pair_valid) valid_cyc++;
            if (overrun)   ovr_cnt++;
            if (frame_err) ferr_cnt++;
            prev_valid = bus.pair_valid;
            prev_acc   = bus.pair_valid && bus.pair_ready;
            prev_val   = {bus.left_out, bus.right_out};
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic step(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    // One lrck segment: lrck/data change with sck low, sck period 16 clk.
    task automatic drive_seg(input logic ch, input logic [W-1:0] word, input int nbits,
                             input int pulse_at, input int rst_at);
        for (int i = 0; i < nbits; i++) begin
            sck = 1'b0;
            if (i == 0) lrck = ch;
            sdin = (i < W) ? word[W-1-i] : 1'($urandom);
            for (int k = 0; k < 8; k++) begin
                if (i == rst_at && k == 2) rst = 1'b1;
                else if (i == rst_at && k == 3) rst = 1'b0;
                step(1);
            end
            sck = 1'b1;
            for (int k = 0; k < 8; k++) begin
                if (i == nbits - 1 && pulse_at >= 0) begin
                    if (k == pulse_at) bus.pair_ready = 1'b1;
                    else if (k == pulse_at + 1) bus.pair_ready = 1'b0;
                end
                step(1);
            end
            if (i == nbits - 1 && pulse_at == 7) bus.pair_ready = 1'b0;
        end
    endtask

    task automatic drive_frame(input logic [W-1:0] l, input logic [W-1:0] r, input int pulse_at);
        drive_seg(1'b0, l, W, -1, -1);
        drive_seg(1'b1, r, W, pulse_at, -1);
    endtask

    function automatic int mag16(input logic [W-1:0] w);
        int v;
        v = int'($signed(w));
        if (v < 0) v = -v;
        if (v > 32767) v = 32767;
        return v;
    endfunction

    // ---------------- tests ----------------
    task automatic test_reset;
        rst = 1'b1;
        bus.pair_ready = 1'b0;
        step(4);
        n_checks++; if (bus.pair_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid got %b want 0", bus.pair_valid); end
        n_checks++; if (bus.left_out !== 16'h0) begin n_fail++; $display("FAIL reset_left got %h want 0000", bus.left_out); end
        n_checks++; if (bus.right_out !== 16'h0) begin n_fail++; $display("FAIL reset_right got %h want 0000", bus.right_out); end
        n_checks++; if ({overrun, frame_err} !== 2'b00) begin n_fail++; $display("FAIL reset_pulses got %b want 00", {overrun, frame_err}); end
        rst = 1'b0;
        step(10);
        n_checks++; if (bus.pair_valid !== 1'b0) begin n_fail++; $display("FAIL idle_valid got %b want 0", bus.pair_valid); end
    endtask

    task automatic test_basic;
        int base, vc, fe, ov;
        base = load_q.size(); vc = valid_cyc; fe = ferr_cnt; ov = ovr_cnt;
        bus.pair_ready = 1'b1;
        for (int f = 0; f < 3; f++) drive_frame(16'hA5C3, 16'h7FFF, -1);
        step(12);
        n_checks++; if (load_q.size() - base != 3) begin n_fail++; $display("FAIL basic_pairs got %0d want 3", load_q.size() - base); end
        n_checks++; if (valid_cyc - vc != 3) begin n_fail++; $display("FAIL basic_valid_cycles got %0d want 3", valid_cyc - vc); end
        for (int i = base; i < load_q.size(); i++) begin
            n_checks++; if (load_q[i] !== 32'hA5C3_7FFF) begin n_fail++; $display("FAIL basic_value[%0d] got %h want A5C37FFF", i - base, load_q[i]); end
        end
        n_checks++; if (ferr_cnt != fe || ovr_cnt != ov) begin n_fail++; $display("FAIL basic_pulses got ferr %0d ovr %0d want 0 0", ferr_cnt - fe, ovr_cnt - ov); end
    endtask

    // Segment-level model: each segment is a whole lrck half with a bit count.
    task automatic test_random;
        localparam int NS = 12;
        logic [W-1:0] wd[NS];
        int nb[NS];
        logic [31:0] exp_q[$];
        logic staged;
        logic [W-1:0] stage_l;
        int exp_ferr, base, fe, ov, r;
        for (int s = 0; s < NS; s++) begin
            wd[s] = 16'($urandom);
            r = int'($urandom_range(0, 5));
            if (r == 3)      nb[s] = int'($urandom_range(1, 15));
            else if (r == 4) nb[s] = int'($urandom_range(17, 20));
            else             nb[s] = W;
        end
        nb[NS-1] = W;
        staged = 1'b0; stage_l = '0; exp_ferr = 0;
        for (int s = 0; s < NS; s++) begin
            if (s > 0 && nb[s-1] > 0 && nb[s-1] < W) begin
                exp_ferr++;
                if ((s - 1) % 2 == 1) staged = 1'b0;
            end
            if (nb[s] >= W) begin
                if (s % 2 == 0) begin stage_l = wd[s]; staged = 1'b1; end
                else if (staged) begin exp_q.push_back({stage_l, wd[s]}); staged = 1'b0; end
            end
        end
        base = load_q.size(); fe = ferr_cnt; ov = ovr_cnt;
        bus.pair_ready = 1'b1;
        for (int s = 0; s < NS; s++) drive_seg(1'(s % 2), wd[s], nb[s], -1, -1);
        step(12);
        n_checks++; if (load_q.size() - base != exp_q.size()) begin n_fail++; $display("FAIL rand_pairs got %0d want %0d", load_q.size() - base, exp_q.size()); end
        for (int i = 0; i < exp_q.size() && base + i < load_q.size(); i++) begin
            n_checks++; if (load_q[base+i] !== exp_q[i]) begin n_fail++; $display("FAIL rand_value[%0d] got %h want %h", i, load_q[base+i], exp_q[i]); end
        end
        n_checks++; if (ferr_cnt - fe != exp_ferr) begin n_fail++; $display("FAIL rand_frame_err got %0d want %0d", ferr_cnt - fe, exp_ferr); end
        n_checks++; if (ovr_cnt != ov) begin n_fail++; $display("FAIL rand_overrun got %0d want 0", ovr_cnt - ov); end
    endtask

    task automatic test_overrun;
        logic [W-1:0] al, ar;
        int base, ov, ch;
        al = 16'($urandom); ar = 16'($urandom);
        base = load_q.size(); ov = ovr_cnt; ch = change_cnt;
        bus.pair_ready = 1'b0;
        drive_frame(al, ar, -1);
        drive_frame(~al, ~ar, -1);
        step(12);
        n_checks++; if (load_q.size() - base != 1) begin n_fail++; $display("FAIL ovr_loads got %0d want 1", load_q.size() - base); end
        n_checks++; if (ovr_cnt - ov != 1) begin n_fail++; $display("FAIL ovr_pulses got %0d want 1", ovr_cnt - ov); end
        n_checks++; if (change_cnt != ch) begin n_fail++; $display("FAIL ovr_held_changed got %0d want 0", change_cnt - ch); end
        n_checks++; if ({bus.pair_valid, bus.left_out, bus.right_out} !== {1'b1, al, ar})
            begin n_fail++; $display("FAIL ovr_held got %b %h %h want 1 %h %h", bus.pair_valid, bus.left_out, bus.right_out, al, ar); end
        bus.pair_ready = 1'b1;
        step(2);
        n_checks++; if (bus.pair_valid !== 1'b0) begin n_fail++; $display("FAIL ovr_drain got %b want 0", bus.pair_valid); end
    endtask

    task automatic test_frame_err;
        logic [W-1:0] l2, r2;
        int base, fe;
        l2 = 16'($urandom); r2 = 16'($urandom);
        base = load_q.size(); fe = ferr_cnt;
        bus.pair_ready = 1'b1;
        drive_seg(1'b0, 16'($urandom), W, -1, -1);
        drive_seg(1'b1, 16'($urandom), 9, -1, -1);
        drive_frame(l2, r2, -1);
        step(12);
        n_checks++; if (ferr_cnt - fe != 1) begin n_fail++; $display("FAIL ferr_pulses got %0d want 1", ferr_cnt - fe); end
        n_checks++; if (load_q.size() - base != 1) begin n_fail++; $display("FAIL ferr_loads got %0d want 1", load_q.size() - base); end
        else begin
            n_checks++; if (load_q[base] !== {l2, r2}) begin n_fail++; $display("FAIL ferr_value got %h want %h", load_q[base], {l2, r2}); end
        end
    endtask

    task automatic test_reset_midword;
        int base, fe, ov;
        base = load_q.size(); fe = ferr_cnt; ov = ovr_cnt;
        bus.pair_ready = 1'b1;
        drive_seg(1'b0, 16'($urandom), W, -1, 6);
        drive_seg(1'b1, 16'($urandom), W, -1, -1);
        drive_frame(16'h0001, 16'h8000, -1);
        step(12);
        n_checks++; if (load_q.size() - base != 1) begin n_fail++; $display("FAIL rstmid_loads got %0d want 1", load_q.size() - base); end
        else begin
            n_checks++; if (load_q[base] !== 32'h0001_8000) begin n_fail++; $display("FAIL rstmid_value got %h want 00018000", load_q[base]); end
        end
        n_checks++; if (ferr_cnt != fe || ovr_cnt != ov) begin n_fail++; $display("FAIL rstmid_pulses got ferr %0d ovr %0d want 0 0", ferr_cnt - fe, ovr_cnt - ov); end
    endtask

    // Sweep a one-cycle ready pulse across the completion of the second pair.
    task automatic test_back_to_back;
        logic [W-1:0] al, ar;
        int hits, ov, cc;
        logic lost;
        hits = 0;
        for (int d = 0; d < 8; d++) begin
            al = 16'($urandom); ar = 16'($urandom);
            bus.pair_ready = 1'b0;
            drive_frame(al, ar, -1);
            ov = ovr_cnt; cc = coin_cnt;
            drive_frame(~al, ~ar, d);
            step(12);
            if (coin_cnt != cc) begin
                hits++;
                n_checks++; if (ovr_cnt != ov || coin_val !== {~al, ~ar})
                    begin n_fail++; $display("FAIL b2b_same_cycle d=%0d got ovr %0d val %h want 0 %h", d, ovr_cnt - ov, coin_val, {~al, ~ar}); end
            end
            lost = (load_q[$] !== {~al, ~ar});
            n_checks++; if (lost != (ovr_cnt - ov == 1))
                begin n_fail++; $display("FAIL b2b_accounting d=%0d got lost %b ovr %0d want lost==ovr", d, lost, ovr_cnt - ov); end
            bus.pair_ready = 1'b1;
            step(3);
            bus.pair_ready = 1'b0;
        end
        n_checks++; if (hits == 0) begin n_fail++; $display("FAIL b2b_hit got %0d want >0", hits); end
    endtask

`ifdef AUDIO_RX_PEAK_EN
    task automatic test_peak;
        logic [W-1:0] r1, r2;
        int er;
        r1 = 16'($urandom); r2 = 16'($urandom);
        er = (mag16(r1) > mag16(r2)) ? mag16(r1) : mag16(r2);
        bus.pair_ready = 1'b1;
        peak_clr = 1'b1; step(1); peak_clr = 1'b0;
        drive_frame(16'h8000, r1, -1);
        drive_frame(16'h0010, r2, -1);
        step(12);
        n_checks++; if (peak_l !== 15'h7FFF) begin n_fail++; $display("FAIL peak_l got %h want 7fff", peak_l); end
        n_checks++; if (int'(peak_r) != er) begin n_fail++; $display("FAIL peak_r got %h want %h", peak_r, er); end
        peak_clr = 1'b1; step(1); peak_clr = 1'b0; step(1);
        n_checks++; if ({peak_l, peak_r} !== 30'h0) begin n_fail++; $display("FAIL peak_clr got %h %h want 0 0", peak_l, peak_r); end
    endtask
`endif

    initial begin
        bus.pair_ready = 1'b0;
        test_reset();
        test_basic();
        test_random();
        test_overrun();
        test_frame_err();
        test_reset_midword();
        test_back_to_back();
`ifdef AUDIO_RX_PEAK_EN
        test_peak();
`endif
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
